// File: rtl/pwr_switch_ack_emu.sv
// Multi-channel power-switch acknowledge emulator with per-direction programmable latency.
// Each channel ramps toward its request and can abort when the request reverts.
module pwr_switch_ack_emu #(
   parameter int unsigned          NUM_CH      = 4,
   parameter int unsigned          LAT_W       = 8,
   parameter logic [NUM_CH-1:0]    ACK_RST     = '0,
   parameter logic [LAT_W-1:0]     DEF_ON_LAT  = 15,
   parameter logic [LAT_W-1:0]     DEF_OFF_LAT = 15
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NUM_CH-1:0] switch_i,
   input  logic              lat_we_i,
   input  logic [LAT_W-1:0]  on_lat_i,
   input  logic [LAT_W-1:0]  off_lat_i,
   output logic [NUM_CH-1:0] ack_o,
   output logic [NUM_CH-1:0] busy_o,
   output logic [NUM_CH-1:0] done_o
);

   typedef enum logic {StSteady, StRamp} state_e;

   state_e            state_q [NUM_CH];
   state_e            state_d [NUM_CH];
   logic [LAT_W-1:0]  cnt_q   [NUM_CH];
   logic [LAT_W-1:0]  cnt_d   [NUM_CH];
   logic [NUM_CH-1:0] ack_q, ack_d;
   logic [NUM_CH-1:0] done_q, done_d;
   logic [LAT_W-1:0]  on_lat_q, on_lat_d;
   logic [LAT_W-1:0]  off_lat_q, off_lat_d;
   logic [LAT_W-1:0]  on_init, off_init;

   // Counter preload is L-1, with a programmed latency of 0 treated as 1.
   assign on_init  = (on_lat_q  == '0) ? '0 : on_lat_q  - 1'b1;
   assign off_init = (off_lat_q == '0) ? '0 : off_lat_q - 1'b1;

   always_comb begin
      on_lat_d  = on_lat_q;
      off_lat_d = off_lat_q;
      if (lat_we_i) begin
         on_lat_d  = on_lat_i;
         off_lat_d = off_lat_i;
      end
   end

   always_comb begin
      ack_d  = ack_q;
      done_d = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         unique case (state_q[i])
            StSteady: begin
               if (switch_i[i] != ack_q[i]) begin
                  state_d[i] = StRamp;
                  cnt_d[i]   = switch_i[i] ? on_init : off_init;
               end
            end
            StRamp: begin
               if (switch_i[i] == ack_q[i]) begin
                  state_d[i] = StSteady;
               end else if (cnt_q[i] == '0) begin
                  ack_d[i]   = ~ack_q[i];
                  done_d[i]  = 1'b1;
                  state_d[i] = StSteady;
               end else begin
                  cnt_d[i] = cnt_q[i] - 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ack_q     <= ACK_RST;
         done_q    <= '0;
         on_lat_q  <= DEF_ON_LAT;
         off_lat_q <= DEF_OFF_LAT;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_q[i] <= StSteady;
            cnt_q[i]   <= '0;
         end
      end else begin
         ack_q     <= ack_d;
         done_q    <= done_d;
         on_lat_q  <= on_lat_d;
         off_lat_q <= off_lat_d;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   always_comb begin
      busy_o = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         busy_o[i] = (state_q[i] == StRamp);
      end
   end

   assign ack_o  = ack_q;
   assign done_o = done_q;

endmodule

// File: tb/tb_pwr_switch_ack_emu.sv
// Scoreboard bench for pwr_switch_ack_emu: expectations are queued per cycle when
// stimulus is driven and compared on the falling edge of that cycle.
module tb_pwr_switch_ack_emu;

   localparam logic [3:0] AckRst = 4'b0010;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sw;
   logic       lat_we;
   logic [7:0] on_lat, off_lat;
   logic [3:0] ack, busy, done;

   int unsigned cyc = 0;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   typedef struct {
      int unsigned cyc;
      int          sel;
      logic [3:0]  mask;
      logic [3:0]  exp;
      string       tag;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   pwr_switch_ack_emu #(
      .NUM_CH     (4),
      .LAT_W      (8),
      .ACK_RST    (AckRst),
      .DEF_ON_LAT (8'd15),
      .DEF_OFF_LAT(8'd15)
   ) u_dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .switch_i (sw),
      .lat_we_i (lat_we),
      .on_lat_i (on_lat),
      .off_lat_i(off_lat),
      .ack_o    (ack),
      .busy_o   (busy),
      .done_o   (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int unsigned c, input int sel, input logic [3:0] mask,
                       input logic [3:0] exp, input string tag);
      exp_t e;
      int   pos;
      e.cyc  = c;
      e.sel  = sel;
      e.mask = mask;
      e.exp  = exp;
      e.tag  = tag;
      pos = sb.size();
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].cyc > c) begin
            pos = i;
            break;
         end
      end
      sb.insert(pos, e);
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         logic [3:0] obs;
         mon_e = sb.pop_front();
         case (mon_e.sel)
            0:       obs = ack;
            1:       obs = busy;
            default: obs = done;
         endcase
         check_eq($sformatf("%s@%0d", mon_e.tag, mon_e.cyc), {28'd0, obs & mon_e.mask},
                  {28'd0, mon_e.exp & mon_e.mask});
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget);
      int b = 0;
      while (sb.size() > 0 && b < budget) begin
         step(1);
         b++;
      end
      if (sb.size() > 0) begin
         check_eq("drain_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic write_lat(input logic [7:0] on_v, input logic [7:0] off_v);
      lat_we  = 1'b1;
      on_lat  = on_v;
      off_lat = off_v;
      step(1);
      lat_we  = 1'b0;
   endtask

   // Request change sampled at edge t on channel ch: ack flips at exactly t+L.
   task automatic expect_ramp(input int ch, input int unsigned t, input int unsigned l,
                              input logic newv);
      logic [3:0] m;
      m = 4'b0001 << ch;
      push(t - 1, 1, m, 4'h0, "pre_busy");
      for (int unsigned k = 0; k < l; k++) begin
         push(t + k, 0, m, {4{~newv}}, "ramp_ack");
         push(t + k, 1, m, 4'hf, "ramp_busy");
         push(t + k, 2, m, 4'h0, "ramp_done");
      end
      push(t + l, 0, m, {4{newv}}, "edge_ack");
      push(t + l, 1, m, 4'h0, "edge_busy");
      push(t + l, 2, m, 4'hf, "edge_done");
      push(t + l + 1, 0, m, {4{newv}}, "post_ack");
      push(t + l + 1, 2, m, 4'h0, "post_done");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned t, ta, r;
      rst     = 1'b1;
      sw      = AckRst;
      lat_we  = 1'b0;
      on_lat  = '0;
      off_lat = '0;
      step(2);
      push(cyc, 0, 4'hf, AckRst, "rst_ack");
      push(cyc, 1, 4'hf, 4'h0, "rst_busy");
      push(cyc, 2, 4'hf, 4'h0, "rst_done");
      rst = 1'b0;
      push(cyc + 3, 0, 4'hf, AckRst, "idle_ack");
      drain(10);

      // Default on-latency ramp on channel 0.
      sw[0] = 1'b1;
      expect_ramp(0, cyc + 1, 15, 1'b1);
      drain(40);

      // Asymmetric latency on channel 1.
      write_lat(8'd3, 8'd7);
      sw[1] = 1'b0;
      expect_ramp(1, cyc + 1, 7, 1'b0);
      drain(40);
      sw[1] = 1'b1;
      expect_ramp(1, cyc + 1, 3, 1'b1);
      drain(40);

      // Abort on channel 2, then a full restart.
      write_lat(8'd10, 8'd7);
      sw[2] = 1'b1;
      t  = cyc + 1;
      ta = t + 4;
      for (int unsigned c = t; c < ta; c++) push(c, 1, 4'b0100, 4'hf, "abort_busy_hi");
      for (int unsigned c = ta; c < ta + 3; c++) push(c, 1, 4'b0100, 4'h0, "abort_busy_lo");
      for (int unsigned c = t; c <= t + 12; c++) begin
         push(c, 0, 4'b0100, 4'h0, "abort_ack");
         push(c, 2, 4'b0100, 4'h0, "abort_done");
      end
      step(4);
      sw[2] = 1'b0;
      step(3);
      sw[2] = 1'b1;
      expect_ramp(2, cyc + 1, 10, 1'b1);
      drain(40);

      // Zero latency, all channels concurrently.
      sw = 4'b0000;
      t  = cyc + 1;
      for (int ch = 0; ch < 3; ch++) expect_ramp(ch, t, 7, 1'b0);
      drain(40);
      write_lat(8'd0, 8'd7);
      sw = 4'b1111;
      t  = cyc + 1;
      for (int ch = 0; ch < 4; ch++) expect_ramp(ch, t, 1, 1'b1);
      push(t + 1, 0, 4'hf, 4'hf, "conc_ack");
      push(t + 1, 2, 4'hf, 4'hf, "conc_done");
      push(t + 2, 2, 4'hf, 4'h0, "conc_done_clr");
      drain(20);

      // Latency write on the same edge a ramp starts: old value applies.
      write_lat(8'd15, 8'd1);
      sw[3] = 1'b0;
      expect_ramp(3, cyc + 1, 1, 1'b0);
      drain(20);
      lat_we = 1'b1;
      on_lat = 8'd2;
      sw[3]  = 1'b1;
      expect_ramp(3, cyc + 1, 15, 1'b1);
      step(1);
      lat_we = 1'b0;
      drain(40);
      sw[3] = 1'b0;
      expect_ramp(3, cyc + 1, 1, 1'b0);
      drain(20);
      sw[3] = 1'b1;
      expect_ramp(3, cyc + 1, 2, 1'b1);
      drain(20);

      // Reset in the middle of a ramp.
      write_lat(8'd2, 8'd12);
      sw[0] = 1'b0;
      t = cyc + 1;
      r = t + 4;
      for (int unsigned c = t; c < r; c++) begin
         push(c, 1, 4'b0001, 4'hf, "mid_busy");
         push(c, 0, 4'b0001, 4'hf, "mid_ack");
      end
      for (int unsigned c = r; c < r + 16; c++) begin
         push(c, 0, 4'hf, AckRst, "rst_mid_ack");
         push(c, 1, 4'hf, 4'h0, "rst_mid_busy");
         push(c, 2, 4'hf, 4'h0, "rst_mid_done");
      end
      step(4);
      rst = 1'b1;
      sw  = AckRst;
      step(2);
      rst = 1'b0;
      drain(40);

      // Shadow latency is back to its default after reset.
      sw[0] = 1'b1;
      expect_ramp(0, cyc + 1, 15, 1'b1);
      drain(40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
